// File: rtl/uart_instr_loader_if.sv
// Write port and status bundle between the UART instruction loader and the
// instruction ROM / user interface.
interface uart_instr_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              instr_transmit_done;
  logic [ADDR_W-1:0] max_addr;
  logic              busy;
  logic              frame_err;

  modport master (
    output wr_en, wr_addr, wr_data, instr_transmit_done, max_addr, busy, frame_err
  );

  modport slave (
    input wr_en, wr_addr, wr_data, instr_transmit_done, max_addr, busy, frame_err
  );
endinterface

// File: rtl/uart_instr_loader.sv
// Receives a program image over 8N1 UART, pairs bytes into 16-bit words (high byte
// first) and writes them to consecutive ROM addresses until full or the line idles.
module uart_instr_loader #(
  parameter int unsigned CLKS_PER_BIT      = 10416,
  parameter int unsigned IDLE_TIMEOUT_BITS = 32,
  parameter int unsigned ADDR_W            = 8,
  parameter int unsigned DATA_W            = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx,
  uart_instr_loader_if.master rom_if
);

  localparam int unsigned CntW          = $clog2(CLKS_PER_BIT);
  localparam int unsigned TimeoutCycles = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TimeoutW      = $clog2(TimeoutCycles);

  localparam logic [CntW-1:0]     BitLast     = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]     HalfLast    = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e              state_q;
  logic                rx_meta_q, rx_s_q, rx_prev_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic [7:0]          hi_byte_q;
  logic                phase_lo_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                have_word_q;
  logic [TimeoutW-1:0] timeout_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                done_q;
  logic [ADDR_W-1:0]   max_addr_q;
  logic                busy_q;
  logic                frame_err_q;
  logic                fall;

  assign fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hi_byte_q   <= '0;
      phase_lo_q  <= 1'b0;
      addr_q      <= '0;
      have_word_q <= 1'b0;
      timeout_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      max_addr_q  <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      wr_en_q   <= 1'b0;

      // Counts consecutive high idle cycles once at least one word has landed.
      if (state_q != StIdle || fall || !rx_s_q || !have_word_q || done_q) begin
        timeout_q <= '0;
      end else begin
        timeout_q <= timeout_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (fall && !done_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (have_word_q && !done_q && rx_s_q && timeout_q == TimeoutLast) begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            phase_lo_q <= 1'b0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
              phase_lo_q  <= 1'b0;
            end else if (!phase_lo_q) begin
              hi_byte_q  <= shift_q;
              phase_lo_q <= 1'b1;
            end else begin
              wr_en_q     <= 1'b1;
              wr_addr_q   <= addr_q;
              wr_data_q   <= {hi_byte_q, shift_q};
              max_addr_q  <= addr_q;
              addr_q      <= addr_q + 1'b1;
              have_word_q <= 1'b1;
              phase_lo_q  <= 1'b0;
              if (addr_q == '1) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rom_if.wr_en               = wr_en_q;
  assign rom_if.wr_addr             = wr_addr_q;
  assign rom_if.wr_data             = wr_data_q;
  assign rom_if.instr_transmit_done = done_q;
  assign rom_if.max_addr            = max_addr_q;
  assign rom_if.busy                = busy_q;
  assign rom_if.frame_err           = frame_err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Randomized and directed checks of uart_instr_loader against a byte-stream model.
module tb_uart_instr_loader;

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    bit         glitch;
    int         gap;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_instr_loader_if #(.ADDR_W(8), .DATA_W(16)) a_if ();
  uart_instr_loader_if #(.ADDR_W(8), .DATA_W(16)) b_if ();

  uart_instr_loader #(
    .CLKS_PER_BIT(16), .IDLE_TIMEOUT_BITS(20), .ADDR_W(8), .DATA_W(16)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .rom_if(a_if)
  );

  // Faster bit rate for the 256-word fill so the run stays short.
  uart_instr_loader #(
    .CLKS_PER_BIT(4), .IDLE_TIMEOUT_BITS(20), .ADDR_W(8), .DATA_W(16)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .rom_if(b_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [23:0] cap_a[$];
  logic [15:0] cap_b[$];
  logic        prev_wr_a, prev_done_a, done_at_last_b;
  int          last_wr_cyc, done_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap_a.delete();
      cap_b.delete();
      prev_wr_a      <= 1'b0;
      prev_done_a    <= 1'b0;
      done_at_last_b <= 1'b0;
    end else begin
      if (a_if.wr_en) begin
        check("wr_pulse_width", {31'd0, prev_wr_a}, 32'd0);
        cap_a.push_back({a_if.wr_addr, a_if.wr_data});
        last_wr_cyc <= cyc;
      end
      if (a_if.instr_transmit_done && !prev_done_a) done_cyc <= cyc;
      prev_wr_a   <= a_if.wr_en;
      prev_done_a <= a_if.instr_transmit_done;
      if (b_if.wr_en) begin
        cap_b.push_back(b_if.wr_data);
        if (b_if.wr_addr == 8'hFF) done_at_last_b <= b_if.instr_transmit_done;
      end
    end
  end

  function automatic frame_t mk(input logic [7:0] b, input bit ok, input bit gl, input int gap);
    frame_t f;
    f.b = b;
    f.stop_ok = ok;
    f.glitch = gl;
    f.gap = gap;
    return f;
  endfunction

  task automatic hold(input bit on_b, input logic v, input int n);
    if (on_b) rx_b = v;
    else rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit on_b, input int cpb, input frame_t f);
    if (f.glitch) begin
      hold(on_b, 1'b0, 4);
      hold(on_b, 1'b1, 2 * cpb);
    end
    hold(on_b, 1'b0, cpb);
    for (int i = 0; i < 8; i++) hold(on_b, f.b[i], cpb);
    hold(on_b, f.stop_ok, cpb);
    if (f.gap > 0) hold(on_b, 1'b1, f.gap * cpb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".wr_en"}, {31'd0, a_if.wr_en}, 32'd0);
    check({name, ".wr_addr"}, {24'd0, a_if.wr_addr}, 32'd0);
    check({name, ".wr_data"}, {16'd0, a_if.wr_data}, 32'd0);
    check({name, ".done"}, {31'd0, a_if.instr_transmit_done}, 32'd0);
    check({name, ".max_addr"}, {24'd0, a_if.max_addr}, 32'd0);
    check({name, ".busy"}, {31'd0, a_if.busy}, 32'd0);
    check({name, ".frame_err"}, {31'd0, a_if.frame_err}, 32'd0);
  endtask

  // Reference: valid bytes queue up in pairs; a bad stop bit empties the pending pair.
  task automatic model(input frame_t fr[$], output logic [23:0] exp_q[$], output bit ferr);
    logic [7:0] pend[$];
    exp_q.delete();
    ferr = 1'b0;
    foreach (fr[i]) begin
      if (!fr[i].stop_ok) begin
        ferr = 1'b1;
        pend.delete();
      end else begin
        pend.push_back(fr[i].b);
        if (pend.size() == 2) begin
          exp_q.push_back({8'(exp_q.size()), pend[0], pend[1]});
          pend.delete();
        end
      end
    end
  endtask

  task automatic run_a(input string name, input frame_t fr[$], input bit chk_latency);
    logic [23:0] exp_q[$];
    bit          ferr;
    int          n;
    model(fr, exp_q, ferr);
    foreach (fr[i]) send_frame(1'b0, 16, fr[i]);
    if (exp_q.size() > 0) begin
      for (int k = 0; k < 1000 && !a_if.instr_transmit_done; k++) @(negedge clk);
    end else begin
      repeat (400) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check({name, ".n_writes"}, cap_a.size(), exp_q.size());
    n = (cap_a.size() < exp_q.size()) ? cap_a.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, ".write"}, {8'd0, cap_a[i]}, {8'd0, exp_q[i]});
    check({name, ".frame_err"}, {31'd0, a_if.frame_err}, {31'd0, ferr});
    check({name, ".done"}, {31'd0, a_if.instr_transmit_done}, {31'd0, exp_q.size() > 0});
    check({name, ".max_addr"}, {24'd0, a_if.max_addr},
          (exp_q.size() > 0) ? exp_q.size() - 1 : 0);
    check({name, ".busy"}, {31'd0, a_if.busy}, {31'd0, exp_q.size() == 0 && fr.size() > 0});
    if (chk_latency) check({name, ".done_latency"}, done_cyc - last_wr_cyc, 32'd320);
  endtask

  initial begin
    frame_t fr[$];
    int     nb;

    do_reset();
    check_all_zero("reset");

    fr = {mk(8'h12, 1, 0, 0), mk(8'h34, 1, 0, 0), mk(8'hAB, 1, 0, 0), mk(8'hCD, 1, 0, 0)};
    run_a("basic", fr, 1'b1);

    do_reset();
    fr = {mk(8'h12, 1, 0, 0), mk(8'h34, 0, 0, 1), mk(8'h56, 1, 0, 0), mk(8'h78, 1, 0, 0)};
    run_a("frame_err", fr, 1'b0);

    do_reset();
    fr = {mk(8'h11, 1, 1, 0), mk(8'h22, 1, 0, 0)};
    run_a("glitch", fr, 1'b0);

    do_reset();
    fr = {mk(8'hAA, 1, 0, 0), mk(8'hBB, 1, 0, 0), mk(8'hCC, 1, 0, 0)};
    run_a("odd_byte", fr, 1'b0);

    // Reset asserted partway through the low byte of a word.
    do_reset();
    send_frame(1'b0, 16, mk(8'h12, 1, 0, 0));
    hold(1'b0, 1'b0, 16);
    hold(1'b0, 1'b0, 16);
    hold(1'b0, 1'b0, 16);
    check("mid_reset.busy_before", {31'd0, a_if.busy}, 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    fr = {mk(8'h34, 1, 0, 0), mk(8'h56, 1, 0, 0)};
    run_a("mid_reset", fr, 1'b0);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      fr.delete();
      nb = $urandom_range(1, 9);
      for (int i = 0; i < nb; i++) begin
        frame_t f;
        f = mk(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 2));
        if (!f.stop_ok && f.gap == 0) f.gap = 1;
        fr.push_back(f);
      end
      run_a($sformatf("rand%0d", r), fr, 1'b0);
    end

    // Fill the whole ROM back-to-back on the fast instance.
    do_reset();
    for (int n = 0; n < 256; n++) begin
      send_frame(1'b1, 4, mk(8'(n), 1, 0, 0));
      send_frame(1'b1, 4, mk(8'(n), 1, 0, 0));
    end
    repeat (20) @(negedge clk);
    check("full.n_writes", cap_b.size(), 32'd256);
    for (int n = 0; n < 256 && n < cap_b.size(); n++) begin
      check("full.data", {16'd0, cap_b[n]}, n * 32'h0101);
    end
    check("full.done_same_edge", {31'd0, done_at_last_b}, 32'd1);
    check("full.done", {31'd0, b_if.instr_transmit_done}, 32'd1);
    check("full.max_addr", {24'd0, b_if.max_addr}, 32'hFF);
    check("full.busy", {31'd0, b_if.busy}, 32'd0);
    send_frame(1'b1, 4, mk(8'h5A, 1, 0, 0));
    send_frame(1'b1, 4, mk(8'hA5, 1, 0, 0));
    repeat (20) @(negedge clk);
    check("full.no_extra_write", cap_b.size(), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
